// File: rtl/xadc_pkg.sv
// xadc_pkg: DRP addressing, ADC width and sequencer state encoding shared by the XADC winner detector.
package xadc_pkg;
    localparam logic [6:0] DRP_AUX_BASE = 7'h10;
    localparam int ADC_BITS = 12;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DECIDE} state_t;
endpackage

// File: rtl/winner_debounce.sv
// winner_debounce: requires HOLD_SWEEPS identical consecutive candidates before the classified output moves.
module winner_debounce #(
    parameter int HOLD_SWEEPS = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       decide_i,
    input  logic       abort_i,
    input  logic       cand_valid_i,
    input  logic [1:0] cand_idx_i,
    output logic [1:0] network_output_o,
    output logic       output_valid_o
);
    localparam logic [7:0] HMAX = 8'(HOLD_SWEEPS);
    logic [2:0] prev_q, cand;
    logic [7:0] hold_q, hold_d;
    assign cand = {cand_valid_i, cand_valid_i ? cand_idx_i : 2'b00};
    assign hold_d = (cand != prev_q) ? 8'd1 : (hold_q >= HMAX ? HMAX : hold_q + 8'd1);
    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) begin
            prev_q <= '0;
            hold_q <= '0;
            network_output_o <= '0;
            output_valid_o <= 1'b0;
        end else if (decide_i) begin
            prev_q <= cand;
            hold_q <= hold_d;
            if (hold_d == HMAX) begin
                network_output_o <= cand[1:0];
                output_valid_o <= cand[2];
            end
        end else if (abort_i) begin
            hold_q <= '0;
        end
endmodule

// File: rtl/xadc_winner_detector.sv
// xadc_winner_detector: per-EOS DRP sweep of aux channels, picks the highest channel above THRESHOLD
// and publishes it through a sweep debouncer.
module xadc_winner_detector
    import xadc_pkg::*;
#(
    parameter int                  NUM_CH      = 4,
    parameter logic [ADC_BITS-1:0] THRESHOLD   = 12'h800,
    parameter int                  HOLD_SWEEPS = 3,
    parameter int                  DRP_TIMEOUT = 255
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESETN,
    input  logic                EOS,
    input  logic                DRDY,
    input  logic [15:0]         DO,
    output logic [6:0]          DADDR,
    output logic                DEN,
    output logic                DWE,
    output logic [15:0]         DI,
    output logic [1:0]          network_output,
    output logic                output_valid,
    output logic [ADC_BITS-1:0] ch_max,
    input  logic                clr_err,
    output logic                timeout_err,
    output logic                overrun_err
);
    localparam logic [1:0] LAST = 2'(NUM_CH - 1);
    localparam logic [7:0] TLIM = 8'(DRP_TIMEOUT - 1);
    state_t state_q;
    logic [1:0] idx_q, run_idx_q;
    logic [ADC_BITS-1:0] run_max_q, ch_max_q, code;
    logic [7:0] tcnt_q;
    logic [6:0] daddr_q;
    logic tout_q, ovr_q, decide, abort, unused_lsbs;
    assign code = DO[15:4];
    assign unused_lsbs = ^DO[3:0];
    assign decide = state_q == S_DECIDE;
    // DRDY on the last allowed cycle still counts as a response
    assign abort = state_q == S_WAIT && !DRDY && tcnt_q == TLIM;
    assign DEN = state_q == S_REQ;
    assign DWE = 1'b0;
    assign DI = '0;
    assign DADDR = daddr_q;
    assign ch_max = ch_max_q;
    assign timeout_err = tout_q;
    assign overrun_err = ovr_q;
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
        if (!S_AXI_ARESETN) begin
            state_q <= S_IDLE;
            idx_q <= '0;
            run_idx_q <= '0;
            run_max_q <= '0;
            ch_max_q <= '0;
            tcnt_q <= '0;
            daddr_q <= '0;
            tout_q <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            ovr_q <= (EOS && state_q != S_IDLE) || (ovr_q && !clr_err);
            tout_q <= abort || (tout_q && !clr_err);
            case (state_q)
                S_IDLE: if (EOS) begin
                    daddr_q <= DRP_AUX_BASE + 7'(idx_q);
                    state_q <= S_REQ;
                end
                S_REQ: state_q <= S_WAIT;
                S_WAIT: if (DRDY) begin
                    tcnt_q <= '0;
                    if (code > run_max_q) begin
                        run_max_q <= code;
                        run_idx_q <= idx_q;
                    end
                    if (idx_q == LAST) state_q <= S_DECIDE;
                    else begin
                        idx_q <= idx_q + 2'd1;
                        daddr_q <= DRP_AUX_BASE + 7'(idx_q + 2'd1);
                        state_q <= S_REQ;
                    end
                end else if (abort) begin
                    tcnt_q <= '0;
                    idx_q <= '0;
                    run_max_q <= '0;
                    run_idx_q <= '0;
                    state_q <= S_IDLE;
                end else tcnt_q <= tcnt_q + 8'd1;
                default: begin
                    ch_max_q <= run_max_q;
                    idx_q <= '0;
                    run_max_q <= '0;
                    run_idx_q <= '0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    winner_debounce #(.HOLD_SWEEPS(HOLD_SWEEPS)) u_debounce (
        .clk_i            (S_AXI_ACLK),
        .rst_ni           (S_AXI_ARESETN),
        .decide_i         (decide),
        .abort_i          (abort),
        .cand_valid_i     (run_max_q >= THRESHOLD),
        .cand_idx_i       (run_idx_q),
        .network_output_o (network_output),
        .output_valid_o   (output_valid)
    );
endmodule

// File: tb/tb_xadc_winner_detector.sv
// tb_xadc_winner_detector: directed DRP sweeps with hand-computed winners, timeout, overrun and reset cases.
module tb_xadc_winner_detector;
    logic        S_AXI_ACLK = 1'b0;
    logic        S_AXI_ARESETN = 1'b0;
    logic        EOS = 1'b0, DRDY = 1'b0, clr_err = 1'b0;
    logic [15:0] DO = '0;
    logic [6:0]  DADDR;
    logic        DEN, DWE, output_valid, timeout_err, overrun_err;
    logic [15:0] DI;
    logic [1:0]  network_output;
    logic [11:0] ch_max;
    int checks = 0, failures = 0;

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    xadc_winner_detector dut (
        .S_AXI_ACLK     (S_AXI_ACLK),
        .S_AXI_ARESETN  (S_AXI_ARESETN),
        .EOS            (EOS),
        .DRDY           (DRDY),
        .DO             (DO),
        .DADDR          (DADDR),
        .DEN            (DEN),
        .DWE            (DWE),
        .DI             (DI),
        .network_output (network_output),
        .output_valid   (output_valid),
        .ch_max         (ch_max),
        .clr_err        (clr_err),
        .timeout_err    (timeout_err),
        .overrun_err    (overrun_err)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [1:0] net, input logic vld, input logic [11:0] mx);
        chk({tag, "_net"}, 16'(network_output), 16'(net));
        chk({tag, "_valid"}, 16'(output_valid), 16'(vld));
        chk({tag, "_chmax"}, 16'(ch_max), 16'(mx));
    endtask

    // Runs one sweep as the DRP responder; stall_ch withholds DRDY, eos_ch injects EOS during WAIT.
    task automatic sweep(input logic [11:0] c0, c1, c2, c3, input int stall_ch = 4,
                         input int eos_ch = 4, input logic clr_too = 1'b0);
        logic [11:0] c [4];
        c = '{c0, c1, c2, c3};
        EOS = 1'b1;
        @(negedge S_AXI_ACLK);
        EOS = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            while (!DEN && n < 20) begin
                @(negedge S_AXI_ACLK);
                n++;
            end
            chk("den_seen", 16'(DEN), 16'd1);
            chk("daddr", 16'(DADDR), 16'(7'h10 + i));
            @(negedge S_AXI_ACLK);
            if (i == stall_ch) begin
                n = 1;
                while (!timeout_err && n < 300) begin
                    @(negedge S_AXI_ACLK);
                    n++;
                end
                chk("timeout_cycles", 16'(n), 16'd256);
                return;
            end
            DRDY = 1'b1;
            DO = {c[i], 4'h5};
            if (i == eos_ch) begin
                EOS = 1'b1;
                clr_err = clr_too;
            end
            @(negedge S_AXI_ACLK);
            DRDY = 1'b0;
            EOS = 1'b0;
            clr_err = 1'b0;
        end
        @(negedge S_AXI_ACLK);
    endtask

    task automatic no_den(input string tag);
        logic seen = 1'b0;
        repeat (4) begin
            @(negedge S_AXI_ACLK);
            seen |= DEN;
        end
        chk(tag, 16'(seen), 16'd0);
    endtask

    initial begin
        repeat (2) @(negedge S_AXI_ACLK);
        outs("reset", 2'd0, 1'b0, 12'h000);
        chk("reset_den", 16'(DEN), 16'd0);
        chk("reset_daddr", 16'(DADDR), 16'd0);
        chk("reset_errs", 16'({timeout_err, overrun_err}), 16'd0);
        chk("tied_dwe_di", {DI[14:0], DWE}, 16'd0);
        S_AXI_ARESETN = 1'b1;
        @(negedge S_AXI_ACLK);

        sweep(12'h100, 12'h900, 12'h300, 12'h200);
        outs("t1_s1", 2'd0, 1'b0, 12'h900);
        sweep(12'h100, 12'h900, 12'h300, 12'h200);
        outs("t1_s2", 2'd0, 1'b0, 12'h900);
        sweep(12'h100, 12'h900, 12'h300, 12'h200);
        outs("t1_s3", 2'd1, 1'b1, 12'h900);

        sweep(12'h000, 12'h900, 12'h000, 12'h000);
        sweep(12'h000, 12'h900, 12'h000, 12'h000);
        outs("t2_w1", 2'd1, 1'b1, 12'h900);
        sweep(12'h000, 12'h000, 12'hB00, 12'h000);
        outs("t2_c2a", 2'd1, 1'b1, 12'hB00);
        sweep(12'h000, 12'h000, 12'hB00, 12'h000);
        outs("t2_c2b", 2'd1, 1'b1, 12'hB00);
        sweep(12'h000, 12'h000, 12'hB00, 12'h000);
        outs("t2_c2c", 2'd2, 1'b1, 12'hB00);

        sweep(12'h7FF, 12'h100, 12'h000, 12'h005);
        sweep(12'h7FF, 12'h100, 12'h000, 12'h005);
        outs("t3_s2", 2'd2, 1'b1, 12'h7FF);
        sweep(12'h7FF, 12'h100, 12'h000, 12'h005);
        outs("t3_s3", 2'd0, 1'b0, 12'h7FF);

        sweep(12'hA00, 12'h000, 12'h000, 12'hA00);
        sweep(12'hA00, 12'h000, 12'h000, 12'hA00);
        outs("tie_s2", 2'd0, 1'b0, 12'hA00);
        sweep(12'hA00, 12'h000, 12'h000, 12'hA00);
        outs("tie_s3", 2'd0, 1'b1, 12'hA00);

        sweep(12'hF00, 12'hF00, 12'hF00, 12'hF00, 2);
        outs("t4_after_to", 2'd0, 1'b1, 12'hA00);
        DRDY = 1'b1;
        DO = 16'hFFF0;
        @(negedge S_AXI_ACLK);
        DRDY = 1'b0;
        no_den("t4_late_drdy_idle");
        outs("t4_late_drdy", 2'd0, 1'b1, 12'hA00);
        sweep(12'hA00, 12'h000, 12'h000, 12'h100);
        outs("t4_restart", 2'd0, 1'b1, 12'hA00);
        chk("t4_to_sticky", 16'(timeout_err), 16'd1);

        sweep(12'hA00, 12'h000, 12'h000, 12'h000, 4, 2);
        chk("t5_ovr", 16'(overrun_err), 16'd1);
        no_den("t5_one_sweep");
        clr_err = 1'b1;
        @(negedge S_AXI_ACLK);
        clr_err = 1'b0;
        chk("t5_clr", 16'({timeout_err, overrun_err}), 16'd0);
        sweep(12'hA00, 12'h000, 12'h000, 12'h000, 4, 1, 1'b1);
        chk("t5_err_wins", 16'(overrun_err), 16'd1);
        clr_err = 1'b1;
        @(negedge S_AXI_ACLK);
        clr_err = 1'b0;
        chk("t5_clr2", 16'(overrun_err), 16'd0);
        outs("t5_outs", 2'd0, 1'b1, 12'hA00);

        EOS = 1'b1;
        @(negedge S_AXI_ACLK);
        EOS = 1'b0;
        @(negedge S_AXI_ACLK);
        DRDY = 1'b1;
        DO = 16'hC000;
        @(negedge S_AXI_ACLK);
        DRDY = 1'b0;
        chk("t6_ch1_req", 16'({DEN, DADDR}), 16'({1'b1, 7'h11}));
        @(negedge S_AXI_ACLK);
        S_AXI_ARESETN = 1'b0;
        #1;
        chk("t6_den_async", 16'(DEN), 16'd0);
        outs("t6_reset", 2'd0, 1'b0, 12'h000);
        chk("t6_daddr", 16'(DADDR), 16'd0);
        @(negedge S_AXI_ACLK);
        S_AXI_ARESETN = 1'b1;
        @(negedge S_AXI_ACLK);
        sweep(12'h100, 12'h900, 12'h300, 12'h200);
        outs("t6_post", 2'd0, 1'b0, 12'h900);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
